// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   state_e     : access FSM encoding (idle / busy / done)
//   WORD_BYTES  : bytes per data-memory word
//   ALIGN_MASK  : byte-offset bits that must be zero for a word access
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES = 8;
  localparam logic [2:0]  ALIGN_MASK = 3'b111;

endpackage

// File: rtl/mem_access_stage_if.sv
// Pipeline-side bus of the MEM stage: EX/MEM register fields in, MEM/WB fields and
// stall/fault/status out.
//   master : EX/MEM side (drives the request fields, observes results)
//   slave  : the MEM stage itself
interface mem_access_stage_if;
  logic [63:0] ALU_VAL;
  logic [63:0] WRITE_DATA;
  logic        MEMREAD;
  logic        MEMWRITE;
  logic [4:0]  REG_DESTINATION;
  logic        REGWRITE_IN;
  logic        MEM2REG_IN;
  logic [31:0] INSTR_IN;

  logic        STALL;
  logic [63:0] MEM_DATA;
  logic [63:0] ALU_VAL_OUT;
  logic [4:0]  REG_DESTINATION_OUT;
  logic        REGWRITE_OUT;
  logic        MEM2REG_OUT;
  logic [31:0] INSTR_OUT;
  logic        FAULT;
  logic [31:0] STALL_COUNT;

  modport master (
    output ALU_VAL, WRITE_DATA, MEMREAD, MEMWRITE, REG_DESTINATION, REGWRITE_IN,
           MEM2REG_IN, INSTR_IN,
    input  STALL, MEM_DATA, ALU_VAL_OUT, REG_DESTINATION_OUT, REGWRITE_OUT,
           MEM2REG_OUT, INSTR_OUT, FAULT, STALL_COUNT
  );

  modport slave (
    input  ALU_VAL, WRITE_DATA, MEMREAD, MEMWRITE, REG_DESTINATION, REGWRITE_IN,
           MEM2REG_IN, INSTR_IN,
    output STALL, MEM_DATA, ALU_VAL_OUT, REG_DESTINATION_OUT, REGWRITE_OUT,
           MEM2REG_OUT, INSTR_OUT, FAULT, STALL_COUNT
  );
endinterface

// File: rtl/mem_access_stage_data_mem_array.sv
// Synchronous single-port 64-bit data RAM.
//   CLK   : clock
//   we    : write mem[idx] <= wdata at the edge
//   re    : capture mem[idx] into rdata at the edge (rdata holds otherwise)
//   idx   : word index
//   wdata : write data
//   rdata : registered read data
// The array and the read register carry no reset.
module data_mem_array #(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [63:0]      wdata,
  output logic [63:0]      rdata
);

  logic [63:0] mem_q [DEPTH_WORDS];
  logic [63:0] rdata_q;

  always_ff @(posedge CLK) begin
    if (we) begin
      mem_q[idx] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the LEGv8 pipeline: owns the data memory and performs LDUR/STUR with a
// fixed LAT-cycle access, stalling upstream while an access is in flight.
//   CLK, RESET : clock, asynchronous active-high reset
//   bus        : request fields from EX/MEM in; load data, gated writeback enable,
//                passthroughs, STALL, FAULT and a saturating STALL_COUNT out
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned LAT         = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  mem_access_stage_if.slave  bus
);

  localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW     = $clog2(LAT) + 1;
  localparam logic [63:0] MemBytes = 64'(DEPTH_WORDS) * 64'(WORD_BYTES);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic              memop;
  logic              fault;
  logic              stall;
  logic              access;
  logic              mem_we;
  logic              mem_re;
  logic [IdxW-1:0]   idx;
  logic [63:0]       rdata;

  assign memop = bus.MEMREAD | bus.MEMWRITE;
  assign fault = memop & (((bus.ALU_VAL[2:0] & ALIGN_MASK) != 3'b000) |
                          (bus.ALU_VAL >= MemBytes));
  assign idx   = bus.ALU_VAL[IdxW+2:3];

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (memop && !fault) begin
          state_d = StBusy;
          cnt_d   = CntW'(LAT - 1);
        end
      end
      StBusy: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Output logic. RESET gates the combinational outputs so that a reset landing
  // mid-access drops STALL and suppresses writeback immediately.
  always_comb begin
    stall  = !RESET && (((state_q == StIdle) && memop && !fault) || (state_q == StBusy));
    access = !RESET && (state_q == StBusy) && (cnt_q == '0);
    // Simultaneous read and write requests are treated as a store.
    mem_we = access && bus.MEMWRITE;
    mem_re = access && bus.MEMREAD && !bus.MEMWRITE;

    bus.STALL               = stall;
    bus.FAULT               = fault;
    bus.STALL_COUNT         = stall_cnt_q;
    bus.MEM_DATA            = '0;
    if (!RESET && (state_q == StDone) && bus.MEMREAD && !bus.MEMWRITE) begin
      bus.MEM_DATA = rdata;
    end
    bus.REGWRITE_OUT        = !RESET && bus.REGWRITE_IN && !stall &&
                              !(bus.MEMREAD && fault);
    bus.ALU_VAL_OUT         = bus.ALU_VAL;
    bus.REG_DESTINATION_OUT = bus.REG_DESTINATION;
    bus.MEM2REG_OUT         = bus.MEM2REG_IN;
    bus.INSTR_OUT           = bus.INSTR_IN;
  end

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_data_mem (
    .CLK   (CLK),
    .we    (mem_we),
    .re    (mem_re),
    .idx   (idx),
    .wdata (bus.WRITE_DATA),
    .rdata (rdata)
  );

endmodule
